// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, the per-cycle
// control bundle and the canned control patterns the FSM selects between.
package pipeline_hazard_ctrl_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic pc_sel_branch;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic ex_mem_flush;
        logic mem_wb_write;
    } ctrl_t;

    // Field order: pc_w, pc_sel, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_w
    localparam ctrl_t CTRL_RUN    = ctrl_t'(9'b1_0_1_0_1_0_1_0_1);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(9'b0_0_0_0_0_0_0_0_0);
    localparam ctrl_t CTRL_BRANCH = ctrl_t'(9'b1_1_1_1_1_1_1_1_1);
    localparam ctrl_t CTRL_HALT   = ctrl_t'(9'b0_0_1_1_1_0_1_0_1);
    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(9'b0_0_0_0_1_1_1_0_1);
    localparam ctrl_t CTRL_RESET  = ctrl_t'(9'b0_0_0_1_0_1_0_1_0);

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status into the sequencer, stage enables,
// flushes, status flags and performance counters out of it.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) ();
    logic [REG_ADDR_W-1:0] if_id_rs;
    logic [REG_ADDR_W-1:0] if_id_rt;
    logic                  if_id_uses_rt;
    logic                  id_ex_mem_read;
    logic [REG_ADDR_W-1:0] id_ex_rt;
    logic                  ex_mem_br_taken;
    logic                  halt_req;
    logic                  mem_busy;

    logic                  pc_write;
    logic                  pc_sel_branch;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_write;
    logic                  id_ex_flush;
    logic                  ex_mem_write;
    logic                  ex_mem_flush;
    logic                  mem_wb_write;
    logic                  halted;
    logic                  mem_timeout_err;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
               ex_mem_br_taken, halt_req, mem_busy,
        input  pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write,
               id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_write,
               halted, mem_timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
               ex_mem_br_taken, halt_req, mem_busy,
        output pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write,
               id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_write,
               halted, mem_timeout_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. Purely combinational.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  if_id_uses_rt,
    output logic                  load_use
);
    // $0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = id_ex_mem_read && (id_ex_rt != '0) &&
                      ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: load-use bubbles, taken-branch flushes,
// data-memory freezes with timeout, and halt drain.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);

    state_t             state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic [DRN_W-1:0]   drain_cnt, drain_nxt;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               err_q;
    logic               load_use;
    logic               stall_inc, flush_inc, err_set;
    ctrl_t              ctrl;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
        .id_ex_mem_read (bus.id_ex_mem_read),
        .id_ex_rt       (bus.id_ex_rt),
        .if_id_rs       (bus.if_id_rs),
        .if_id_rt       (bus.if_id_rt),
        .if_id_uses_rt  (bus.if_id_uses_rt),
        .load_use       (load_use)
    );

    always_comb begin
        ctrl      = CTRL_RUN;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        drain_nxt = drain_cnt;
        flush_inc = 1'b0;
        err_set   = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (bus.mem_busy) begin
                    ctrl = CTRL_FREEZE;
                    if (state == RUN) begin
                        state_nxt = MEM_WAIT;
                        wait_nxt  = WAIT_W'(1);
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        err_set   = 1'b1;
                        state_nxt = HALTED;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    // Release from MEM_WAIT evaluates the RUN rules in the same cycle.
                    state_nxt = RUN;
                    if (bus.ex_mem_br_taken) begin
                        ctrl      = CTRL_BRANCH;
                        flush_inc = 1'b1;
                    end else if (bus.halt_req) begin
                        ctrl      = CTRL_HALT;
                        state_nxt = DRAIN;
                        drain_nxt = DRN_W'(DRAIN_CYCLES);
                    end else if (load_use) begin
                        ctrl = CTRL_BUBBLE;
                    end
                end
            end
            DRAIN: begin
                if (bus.mem_busy) begin
                    ctrl = CTRL_FREEZE;
                end else if (bus.ex_mem_br_taken) begin
                    // Halt came from the wrong path; squash it and take the branch.
                    ctrl      = CTRL_BRANCH;
                    flush_inc = 1'b1;
                    state_nxt = RUN;
                end else begin
                    ctrl = CTRL_HALT;
                    if (drain_cnt == DRN_W'(1)) state_nxt = HALTED;
                    else                        drain_nxt = drain_cnt - DRN_W'(1);
                end
            end
            default: ctrl = CTRL_FREEZE;
        endcase
        if (rst) ctrl = CTRL_RESET;
    end

    assign stall_inc = ((state == RUN) || (state == MEM_WAIT)) && !ctrl.pc_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
            if (stall_inc && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
            if (err_set)                  err_q   <= 1'b1;
        end
    end

    assign bus.pc_write        = ctrl.pc_write;
    assign bus.pc_sel_branch   = ctrl.pc_sel_branch;
    assign bus.if_id_write     = ctrl.if_id_write;
    assign bus.if_id_flush     = ctrl.if_id_flush;
    assign bus.id_ex_write     = ctrl.id_ex_write;
    assign bus.id_ex_flush     = ctrl.id_ex_flush;
    assign bus.ex_mem_write    = ctrl.ex_mem_write;
    assign bus.ex_mem_flush    = ctrl.ex_mem_flush;
    assign bus.mem_wb_write    = ctrl.mem_wb_write;
    assign bus.halted          = (state == HALTED);
    assign bus.mem_timeout_err = err_q;
    assign bus.stall_cnt       = stall_q;
    assign bus.flush_cnt       = flush_q;

endmodule
